fma_dot_sequencer: RTL and testbench
====================================

// Module: fma_dot_sequencer
// PURPOSE
//  Sequences one FMA datapath instance to compute one dot product per job: acc = bias + sum(a[i]*b[i]).
//  Operands are bf16 (16b) and the accumulator is fp32 (32b).
//  Operand pairs stream in over valid/ready, one FMA per cycle; the fp32 result leaves over valid/ready.
//  Sits between the systolic PE operand feeders and the result collector.
//  FMA numerics belong to the FMA instance; this block does not alter them.
// PARAMETERS
//  LEN_W   8  width of the job length field; max beats per job = 2**LEN_W-1
//  IN_REG  1  1 = register the operand pair before the FMA (adds 1 cycle); 0 = feed the FMA directly
// PORTS
//  clk        in   1      single clock; all state changes on posedge
//  rst_n      in   1      synchronous reset, active-low
//  start      in   1      job request; sampled only in IDLE
//  len        in   LEN_W  number of operand pairs in the job; sampled with start
//  bias       in   32     initial fp32 accumulator value; sampled with start
//  abort      in   1      kill the current job; highest priority after reset
//  busy       out  1      high in every state except IDLE
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      sequencer accepts a pair this cycle
//  in_a       in   16     bf16 operand a
//  in_b       in   16     bf16 operand b
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts the result
//  out_data   out  32     fp32 dot-product result
//  beat_cnt   out  LEN_W  pairs accepted so far in the current job
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE.
//   busy=0, in_ready=0, out_valid=0, out_data=0, beat_cnt=0; accumulator=0; operand register invalid.
//  States
//   IDLE   start=1 & len!=0: latch len into rem, bias into acc, beat_cnt=0, go RUN.
//          start=1 & len==0: acc=bias, go DONE; out_valid is high the cycle after start.
//   RUN    in_ready = (rem!=0). Handshake: a beat transfers when in_valid & in_ready at posedge.
//          On each transfer: rem-=1, beat_cnt+=1.
//          IN_REG=0: acc <= FMA(in_a, in_b, acc) in the same cycle.
//          IN_REG=1: the pair is captured into the operand register; acc <= FMA(reg_a, reg_b, acc) the cycle after.
//          When the last transfer happens (rem 1->0): go DONE if IN_REG=0, else go FLUSH.
//          in_valid low stalls the job; no state change and no acc update.
//   FLUSH  (IN_REG=1 only) one cycle: the final registered pair updates acc; go DONE.
//   DONE   out_valid=1, out_data=acc; both held stable until out_valid & out_ready.
//          On that handshake: go IDLE, out_valid=0.
//  Latency, last pair accepted at cycle N:
//   out_valid rises at N+1 for IN_REG=0, N+2 for IN_REG=1. Throughput is 1 pair/cycle, no bubbles.
//   Minimum gap between jobs: one IDLE cycle after the result handshake.
//  Boundaries
//   start while busy: ignored; no effect on len, bias or acc.
//   abort=1 in any state: next state IDLE, operand register invalidated, out_valid=0, beat_cnt=0.
//     No result is emitted. A start in the same cycle as abort is ignored.
//   in_valid held high past the job end: extra pairs are not accepted (in_ready=0 once rem=0).
//   len = 2**LEN_W-1: rem must not wrap; beat_cnt ends at len exactly.
//   out_ready high before out_valid: no effect; the handshake occurs on the first DONE cycle.
//  Arithmetic: the FMA output is registered into acc as-is (32b).
//   No rounding, normalisation or zero fix-up is done in this block.
// STRUCTURE
//  Shared package fma_pkg:
//   typedef logic [15:0] bf16_t; typedef logic [31:0] fp32_t;
//   typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_FLUSH, SEQ_DONE} seq_state_t.
//  Sub-module: exactly one FMA instance (the existing combinational unit); its mul_out port is left unconnected.
//  Everything else is local: FSM, rem and beat_cnt counters, operand register, accumulator register.
// TESTING
//  Data checks compare against a chained golden model of FMA(a, b, acc).
//  1 len=0, bias=0x40400000 -> out_valid at start+1, out_data=0x40400000, in_ready never high.
//  2 len=4, IN_REG=1, pairs (0x3F80,0x4000) x4 back-to-back, bias=0x3F800000, out_ready=1
//    -> 4 transfers in 4 cycles, out_valid at last+2, out_data = model, beat_cnt=4.
//  3 len=3, in_valid toggling 1,0,1,0,1 -> exactly 3 transfers.
//    acc updates only on transfers; result matches the gap-free run.
//  4 out_ready held low 5 cycles in DONE -> out_data and out_valid stable; start pulses ignored; IDLE after ready.
//  5 abort at beat 2 of len=6 -> IDLE next cycle, busy=0, no out_valid.
//    A following job with len=1 produces a correct result.
//  6 len=255 (LEN_W=8), stream held valid -> 255 transfers, in_ready drops at rem=0.
//    in_valid kept high for 3 extra cycles is not consumed.

Source files
------------

// File: rtl/fma_pkg.sv
// rtl/fma_pkg.sv - shared bf16/fp32 types and sequencer state encoding
package fma_pkg;
  typedef logic [15:0] bf16_t;
  typedef logic [31:0] fp32_t;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_RUN, SEQ_FLUSH, SEQ_DONE} seq_state_t;

  localparam fp32_t FP32_QNAN = 32'h7FC0_0000;
  localparam fp32_t FP32_INF  = 32'h7F80_0000;
endpackage

// File: rtl/fma_dot_sequencer_fma.sv
// rtl/fma_dot_sequencer_fma.sv - combinational bf16*bf16+fp32 fused multiply-add, single RNE rounding
module fma_dot_sequencer_fma
  import fma_pkg::*;
(
  input  bf16_t a,
  input  bf16_t b,
  input  fp32_t c,
  output fp32_t mul_out,
  output fp32_t fma_out
);
  logic               aZero, bZero, cZero, pZero, special, prodSign;
  logic               bigIsProd, sBig, sSmall, sticky, roundUp;
  logic [15:0]        mp;
  logic [24:0]        mProd, mAdd, mBig, mSmall;
  logic signed [11:0] eProd, eAdd, eBig, eSmall, diff, eRes, eMul;
  logic [5:0]         sh, lz;
  logic [107:0]       shifted;
  logic [54:0]        xBig, ySmall, sum, norm;
  logic [24:0]        mantRnd;

  always_comb begin
    aZero    = (a[14:7] == 8'd0);
    bZero    = (b[14:7] == 8'd0);
    cZero    = (c[30:23] == 8'd0);
    pZero    = aZero | bZero;
    special  = (&a[14:7]) | (&b[14:7]) | (&c[30:23]);
    prodSign = a[15] ^ b[15];
    mp       = 16'({1'b1, a[6:0]}) * 16'({1'b1, b[6:0]});

    // Both operands are scaled so the leading one sits at bit 24; zeros get a tiny exponent.
    mProd = pZero ? 25'd0 : (mp[15] ? {mp, 9'd0} : {mp[14:0], 10'd0});
    eProd = pZero ? -12'sd1024 :
            $signed({4'd0, a[14:7]}) + $signed({4'd0, b[14:7]}) - 12'sd278 + $signed({11'd0, mp[15]});
    mAdd  = cZero ? 25'd0 : {1'b1, c[22:0], 1'b0};
    eAdd  = cZero ? -12'sd1024 : $signed({4'd0, c[30:23]}) - 12'sd151;

    bigIsProd = (eProd > eAdd) || ((eProd == eAdd) && (mProd >= mAdd));
    mBig   = bigIsProd ? mProd : mAdd;
    mSmall = bigIsProd ? mAdd : mProd;
    eBig   = bigIsProd ? eProd : eAdd;
    eSmall = bigIsProd ? eAdd : eProd;
    sBig   = bigIsProd ? prodSign : c[31];
    sSmall = bigIsProd ? c[31] : prodSign;

    diff    = eBig - eSmall;
    sh      = (diff > 12'sd63) ? 6'd63 : diff[5:0];
    shifted = {mSmall, 29'd0, 54'd0} >> sh;
    sticky  = |shifted[53:0];
    xBig    = {1'b0, mBig, 29'd0};
    ySmall  = {1'b0, shifted[107:55], shifted[54] | sticky};
    sum     = (sBig ^ sSmall) ? (xBig - ySmall) : (xBig + ySmall);

    lz = 6'd0;
    for (int i = 0; i < 55; i++) begin
      if (sum[i]) lz = 6'(54 - i);
    end
    norm    = sum << lz;
    roundUp = norm[30] & ((|norm[29:0]) | norm[31]);
    mantRnd = {1'b0, norm[54:31]} + {24'd0, roundUp};
    eRes    = eBig + 12'sd152 - $signed({6'd0, lz}) + $signed({11'd0, mantRnd[24]});

    if (special)              fma_out = FP32_QNAN;
    else if (sum == 55'd0)    fma_out = 32'd0;
    else if (eRes >= 12'sd255) fma_out = {sBig, FP32_INF[30:0]};
    else if (eRes <= 12'sd0)  fma_out = {sBig, 31'd0};
    else fma_out = {sBig, eRes[7:0], mantRnd[24] ? mantRnd[23:1] : mantRnd[22:0]};

    eMul = $signed({4'd0, a[14:7]}) + $signed({4'd0, b[14:7]}) - 12'sd127 + $signed({11'd0, mp[15]});
    if (special)               mul_out = FP32_QNAN;
    else if (pZero || eMul <= 12'sd0) mul_out = {prodSign, 31'd0};
    else if (eMul >= 12'sd255) mul_out = {prodSign, FP32_INF[30:0]};
    else mul_out = {prodSign, eMul[7:0], mp[15] ? {mp[14:0], 8'd0} : {mp[13:0], 9'd0}};
  end
endmodule

// File: rtl/fma_dot_sequencer.sv
// rtl/fma_dot_sequencer.sv - streams bf16 operand pairs through one FMA to produce bias + sum(a*b)
module fma_dot_sequencer
  import fma_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int IN_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      bias,
  input  logic             abort,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [LEN_W-1:0] beat_cnt
);
  seq_state_t       state;
  logic [LEN_W-1:0] rem;
  fp32_t            acc, fmaOut;
  bf16_t            regA, regB, fmaA, fmaB;
  logic             regValid, fire, lastBeat, accEn;

  assign busy      = (state != SEQ_IDLE);
  assign in_ready  = (state == SEQ_RUN) && (rem != '0);
  assign fire      = in_valid && in_ready;
  assign lastBeat  = fire && (rem == LEN_W'(1));
  assign out_valid = (state == SEQ_DONE);
  assign out_data  = acc;
  assign fmaA      = (IN_REG != 0) ? regA : in_a;
  assign fmaB      = (IN_REG != 0) ? regB : in_b;
  assign accEn     = (IN_REG != 0) ? regValid : fire;

  fma_dot_sequencer_fma uFma (
    .a       (fmaA),
    .b       (fmaB),
    .c       (acc),
    .mul_out (),
    .fma_out (fmaOut)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SEQ_IDLE;
      rem      <= '0;
      beat_cnt <= '0;
      acc      <= '0;
      regA     <= '0;
      regB     <= '0;
      regValid <= 1'b0;
    end else if (abort) begin
      state    <= SEQ_IDLE;
      rem      <= '0;
      beat_cnt <= '0;
      regValid <= 1'b0;
    end else begin
      regValid <= (IN_REG != 0) && fire;
      if (fire) begin
        regA     <= in_a;
        regB     <= in_b;
        rem      <= rem - 1'b1;
        beat_cnt <= beat_cnt + 1'b1;
      end
      if (accEn) acc <= fmaOut;
      case (state)
        SEQ_IDLE: begin
          if (start) begin
            rem      <= len;
            beat_cnt <= '0;
            acc      <= bias;
            state    <= (len == '0) ? SEQ_DONE : SEQ_RUN;
          end
        end
        SEQ_RUN:   if (lastBeat) state <= (IN_REG != 0) ? SEQ_FLUSH : SEQ_DONE;
        SEQ_FLUSH: state <= SEQ_DONE;
        SEQ_DONE:  if (out_ready) state <= SEQ_IDLE;
        default:   state <= SEQ_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fma_dot_sequencer.sv
// tb/tb_fma_dot_sequencer.sv - directed vector bench for fma_dot_sequencer
module tb_fma_dot_sequencer;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, start, abort, busy, in_valid, in_ready, out_valid, out_ready;
  logic [LEN_W-1:0] len, beat_cnt;
  logic [31:0]      bias, out_data;
  logic [15:0]      in_a, in_b;
  int               total = 0;
  int               bad = 0;

  typedef struct {
    int              n;
    logic [31:0]     b0;
    logic [3:0][15:0] va;
    logic [3:0][15:0] vb;
    logic [31:0]     expd;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  fma_dot_sequencer #(.LEN_W(LEN_W), .IN_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .bias(bias), .abort(abort),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .beat_cnt(beat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, req);
    end
  endtask

  function automatic real bfToReal(input logic [15:0] v);
    logic [10:0] e;
    if (v[14:7] == 8'd0) return 0.0;
    e = {3'd0, v[14:7]} + 11'd896;
    return $bitstoreal({v[15], e, v[6:0], 45'd0});
  endfunction

  function automatic real fpToReal(input logic [31:0] v);
    logic [10:0] e;
    if (v[30:23] == 8'd0) return 0.0;
    e = {3'd0, v[30:23]} + 11'd896;
    return $bitstoreal({v[31], e, v[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] realToFp(input real r);
    logic [63:0] bits;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    bits = $realtobits(r);
    e = bits[62:52] - 11'd896;
    return {bits[63], e[7:0], bits[51:29]};
  endfunction

  function automatic logic [31:0] fmaModel(input logic [15:0] a, input logic [15:0] b, input logic [31:0] c);
    return realToFp(bfToReal(a) * bfToReal(b) + fpToReal(c));
  endfunction

  task automatic doJob(input string tag, input int n, input logic [31:0] b0,
                       input logic [3:0][15:0] va, input logic [3:0][15:0] vb,
                       input logic [31:0] expd, input bit gappy, input bit extra, input int hold);
    int idx, cyc, xfer, tick;
    start = 1'b1; len = n[LEN_W-1:0]; bias = b0; out_ready = (hold == 0);
    @(negedge clk);
    start = 1'b0;
    idx = 0; cyc = 0; xfer = 0; tick = 0;
    while (idx < n && cyc < 2000) begin
      in_valid = gappy ? !tick[0] : 1'b1;
      in_a = va[idx[1:0]];
      in_b = vb[idx[1:0]];
      if (in_valid && in_ready) begin
        idx++;
        xfer++;
      end
      @(negedge clk);
      cyc++;
      tick++;
    end
    in_valid = extra;
    check({tag, " transfers"}, 32'(xfer), 32'(n));
    if (n > 0) begin
      check({tag, " flush no out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " flush in_ready low"}, 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    check({tag, " out_valid rise"}, 32'(out_valid), 32'd1);
    check({tag, " done in_ready low"}, 32'(in_ready), 32'd0);
    for (int h = 0; h < hold; h++) begin
      check({tag, " hold valid"}, 32'(out_valid), 32'd1);
      check({tag, " hold data"}, out_data, expd);
      check({tag, " hold beat_cnt"}, 32'(beat_cnt), 32'(n));
      start = h[0]; len = 8'd5; bias = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    start = 1'b0; out_ready = 1'b1;
    check({tag, " out_data"}, out_data, expd);
    check({tag, " beat_cnt"}, 32'(beat_cnt), 32'(n));
    @(negedge clk);
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " idle in_ready"}, 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] m;
    vecs[0] = '{4, 32'h3F80_0000, {16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80},
                {16'h4000, 16'h4000, 16'h4000, 16'h4000}, 32'h4110_0000};
    vecs[1] = '{3, 32'h0000_0000, {16'h0000, 16'h3F00, 16'hBF80, 16'h4040},
                {16'h0000, 16'h3F00, 16'h4000, 16'h4040}, 32'h40E8_0000};
    vecs[2] = '{2, 32'hC000_0000, {16'h0000, 16'h0000, 16'h3F80, 16'h3F80},
                {16'h0000, 16'h0000, 16'h0000, 16'h4000}, 32'h0000_0000};
    vecs[3] = '{1, 32'h4040_0000, {16'h0000, 16'h0000, 16'h0000, 16'h4080},
                {16'h0000, 16'h0000, 16'h0000, 16'hBF80}, 32'hBF80_0000};
    vecs[4] = '{0, 32'h4040_0000, {16'h0000, 16'h0000, 16'h0000, 16'h0000},
                {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 32'h4040_0000};
    vecs[5] = '{4, 32'h0000_0000, {16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00},
                {16'h3F00, 16'h3F00, 16'h3F00, 16'h3F00}, 32'h3F80_0000};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    len = '0; bias = '0; in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd0);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", out_data, 32'd0);
    check("reset beat_cnt", 32'(beat_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++)
      doJob($sformatf("vec%0d", v), vecs[v].n, vecs[v].b0, vecs[v].va, vecs[v].vb,
            vecs[v].expd, 1'b0, 1'b0, 0);

    doJob("gappy", vecs[1].n, vecs[1].b0, vecs[1].va, vecs[1].vb, vecs[1].expd, 1'b1, 1'b0, 0);
    doJob("stall", vecs[0].n, vecs[0].b0, vecs[0].va, vecs[0].vb, vecs[0].expd, 1'b0, 1'b0, 5);

    // abort in the middle of a six-beat job, with a start request in the same cycle
    start = 1'b1; len = 8'd6; bias = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_a = 16'h4000; in_b = 16'h4000;
    check("abort pre in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("abort pre beat_cnt", 32'(beat_cnt), 32'd2);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort beat_cnt", 32'(beat_cnt), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check("abort no out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
    end
    abort = 1'b1; start = 1'b1; len = 8'd3;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort+start idle", 32'(busy), 32'd0);
    doJob("post-abort", vecs[3].n, vecs[3].b0, vecs[3].va, vecs[3].vb, vecs[3].expd, 1'b0, 1'b0, 0);

    // full-length job; golden value comes from the chained model
    begin
      logic [3:0][15:0] fa, fb;
      fa = {16'h3F80, 16'h3F00, 16'h4000, 16'h3F80};
      fb = {16'h3F80, 16'h4000, 16'h3F00, 16'h3F80};
      m = 32'h0000_0000;
      for (int i = 0; i < 255; i++) m = fmaModel(fa[i % 4], fb[i % 4], m);
      doJob("len255", 255, 32'h0000_0000, fa, fb, m, 1'b0, 1'b1, 0);
      check("len255 golden", out_data, 32'h437F_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
